// File: rtl/cpu_btn_pkg.sv
// Shared definitions for the push-button controller: register map and repeat-FSM states.
package cpu_btn_pkg;

  localparam logic [1:0] ADDR_DATA         = 2'd0;
  localparam logic [1:0] ADDR_RAW          = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK     = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd3;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/cpu_btn_debounce.sv
// One button lane: 2-flop synchronizer, debounce counter, press-event pulse and,
// with CPU_BTN_AUTOREPEAT_EN defined, an auto-repeat FSM.
module cpu_btn_debounce
  import cpu_btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic sync_level,
  output logic db_level,
  output logic press_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             press_reg;
  logic             differ;
  logic             settle;

  assign differ = sync_reg[1] ^ level_reg;
  assign settle = differ && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg  <= 2'b11;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], btn_n};
      press_reg <= settle && !sync_reg[1];
      if (settle) begin
        level_reg <= sync_reg[1];
        cnt_reg   <= '0;
      end else if (differ) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign sync_level = sync_reg[1];
  assign db_level   = level_reg;

`ifdef CPU_BTN_AUTOREPEAT_EN
  logic        press_upd;
  logic        release_upd;
  rpt_state_e  state_reg, state_next;
  logic [31:0] timer_reg, timer_next;
  logic        rpt_fire;
  logic        rpt_reg;

  assign press_upd   = settle && !sync_reg[1];
  assign release_upd = settle &&  sync_reg[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= RPT_IDLE;
      timer_reg <= '0;
      rpt_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      rpt_reg   <= rpt_fire;
    end
  end

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg + 32'd1;
    case (state_reg)
      RPT_IDLE: begin
        timer_next = '0;
        if (press_upd) state_next = RPT_DELAY;
      end
      RPT_DELAY: begin
        if (timer_reg == 32'(REPEAT_DELAY - 1)) begin
          state_next = RPT_REPEAT;
          timer_next = '0;
        end
      end
      RPT_REPEAT: begin
        if (timer_reg == 32'(REPEAT_PERIOD - 1)) timer_next = '0;
      end
      default: begin
        state_next = RPT_IDLE;
        timer_next = '0;
      end
    endcase
    // A debounced release cancels any pending repeat without an event.
    if (release_upd) begin
      state_next = RPT_IDLE;
      timer_next = '0;
    end
  end

  always_comb begin
    rpt_fire = 1'b0;
    if (!release_upd) begin
      if (state_reg == RPT_DELAY && timer_reg == 32'(REPEAT_DELAY - 1))
        rpt_fire = 1'b1;
      if (state_reg == RPT_REPEAT && timer_reg == 32'(REPEAT_PERIOD - 1))
        rpt_fire = 1'b1;
    end
  end

  assign press_evt = press_reg | rpt_reg;
`else
  assign press_evt = press_reg;
`endif

endmodule

// File: rtl/cpu_btn_edit_ctrl.sv
// Avalon-MM push-button controller: debounced levels, edge capture with W1C and masked IRQ.
// Optional auto-repeat is enabled by defining CPU_BTN_AUTOREPEAT_EN.
module cpu_btn_edit_ctrl
  import cpu_btn_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [N_BTN-1:0] in_port,
  output logic             irq
);

  logic [N_BTN-1:0] raw_level;
  logic [N_BTN-1:0] db_level;
  logic [N_BTN-1:0] press_evt;
  logic [N_BTN-1:0] mask_reg, mask_next;
  logic [N_BTN-1:0] cap_reg, cap_next;
  logic [31:0]      readdata_reg, readdata_next;
  logic             wr_en;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      cpu_btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_debounce (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_n      (in_port[gi]),
        .sync_level (raw_level[gi]),
        .db_level   (db_level[gi]),
        .press_evt  (press_evt[gi])
      );
    end

    if (N_BTN < 32) begin : g_unused
      logic unused_wd;
      assign unused_wd = ^writedata[31:N_BTN];
    end
  endgenerate

  assign wr_en = chipselect && !write_n;

  always_comb begin
    mask_next = mask_reg;
    cap_next  = cap_reg;
    if (wr_en && address == ADDR_IRQ_MASK)
      mask_next = writedata[N_BTN-1:0];
    if (wr_en && address == ADDR_EDGE_CAPTURE)
      cap_next = cap_reg & ~writedata[N_BTN-1:0];
    // Applied after the clear so a coincident press keeps its bit set.
    cap_next = cap_next | press_evt;
  end

  always_comb begin
    readdata_next = '0;
    case (address)
      ADDR_DATA:         readdata_next = 32'(db_level);
      ADDR_RAW:          readdata_next = 32'(raw_level);
      ADDR_IRQ_MASK:     readdata_next = 32'(mask_reg);
      ADDR_EDGE_CAPTURE: readdata_next = 32'(cap_reg);
      default:           readdata_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg     <= '0;
      cap_reg      <= '0;
      readdata_reg <= '0;
    end else begin
      mask_reg     <= mask_next;
      cap_reg      <= cap_next;
      readdata_reg <= readdata_next;
    end
  end

  assign readdata = readdata_reg;
  assign irq      = |(cap_reg & mask_reg);

endmodule

// File: doc/cpu_btn_edit_ctrl.md
CPU_BTN_EDIT_CTRL -- requirements
Module: cpu_btn_edit_ctrl

Interface
REQ-001 Parameter N_BTN, default 3, number of push-buttons (1..32).
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, stable-input cycles needed to accept a level change (1 ms at 50 MHz); minimum 2.
REQ-003 Parameter REPEAT_DELAY, default 25000000, held cycles before the first auto-repeat (0.5 s).
REQ-004 Parameter REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeats (0.1 s).
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 address  input  2  Avalon-MM register select.
REQ-008 chipselect  input  1  Avalon-MM slave select.
REQ-009 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  registered read data.
REQ-012 in_port  input  N_BTN  raw asynchronous buttons, active-low (0 = pressed).
REQ-013 irq  output  1  level interrupt to the CPU.

Function
REQ-014 Each in_port bit SHALL pass a 2-flop synchronizer before any other use.
REQ-015 Debounce per bit: a counter SHALL advance while the synchronized bit differs from the debounced level and clear to 0 when they are equal; on reaching DEBOUNCE_CYCLES-1 while still differing, the debounced level SHALL update next cycle and the counter clears.
REQ-016 A press event SHALL be a one-cycle pulse when a debounced bit goes 1->0; releases generate no event.
REQ-017 Register map: 0 = DATA (RO, debounced levels); 1 = RAW (RO, synchronized levels); 2 = IRQ_MASK (RW, N_BTN bits); 3 = EDGE_CAPTURE (RO bits, write-1-to-clear).
REQ-018 readdata SHALL update every cycle with the selected register, zero-extended to 32 bits, giving one-cycle read latency regardless of chipselect.
REQ-019 Writes take effect when chipselect=1 and write_n=0; writes to addresses 0 and 1 SHALL be ignored.
REQ-020 EDGE_CAPTURE bit i SHALL be set by a press event on bit i; if set and a write-1-clear hit the same bit in the same cycle, set SHALL win.
REQ-021 irq SHALL equal the OR of (EDGE_CAPTURE AND IRQ_MASK), derived from registered state only.
REQ-022 Simultaneous press events on several bits SHALL each set their own capture bit in the same cycle.

Reset
REQ-023 On reset_n=0: synchronizers and debounced levels to all-ones (released), counters 0, IRQ_MASK 0, EDGE_CAPTURE 0, readdata 0, irq 0, repeat FSMs IDLE.
REQ-024 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no event produced.

Configuration
REQ-025 Macro CPU_BTN_AUTOREPEAT_EN: when defined, each bit SHALL carry an FSM IDLE->DELAY (on press)->REPEAT (after REPEAT_DELAY held cycles, emitting one press event)->REPEAT (every REPEAT_PERIOD cycles, emitting one press event); any state -> IDLE on debounced release, no event.
REQ-026 When CPU_BTN_AUTOREPEAT_EN is undefined, no repeat logic SHALL be synthesized, REPEAT_* parameters SHALL be unused, and a held button yields exactly one event.

Structure
REQ-027 Shared package cpu_btn_pkg SHALL hold the register address constants (DATA, RAW, IRQ_MASK, EDGE_CAPTURE) and the repeat-FSM state enum.
REQ-028 Per-bit synchronizer, debounce counter and repeat FSM SHALL live in sub-module cpu_btn_debounce, instantiated N_BTN times.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-029 in_port[0] 1->0 held 10 cycles -> DATA reads 3'b110, EDGE_CAPTURE=3'b001; irq stays 0 with IRQ_MASK=0.
REQ-030 in_port[1] glitch 0 for 3 cycles then 1 -> DATA stays 3'b111, EDGE_CAPTURE stays 0.
REQ-031 IRQ_MASK=3'b010, press btn1 -> irq=1; write 3'b010 to address 3 -> irq=0 the following cycle.
REQ-032 W1C to address 3 in the same cycle as a btn2 press event -> EDGE_CAPTURE[2]=1 after the write.
REQ-033 With CPU_BTN_AUTOREPEAT_EN, hold btn0 for 60 cycles after debounce -> events at +0, +20, +28, +36, +44, +52; release -> no further events.
REQ-034 Reset pulsed at debounce count 2 -> all registers 0, DATA 3'b111, no capture bit set afterwards.
